// File: rtl/seg_display_pkg.sv
// Shared types and helpers for the multiplexed decimal display driver.
// Holds the conversion FSM state type, the BCD digit-count helper, and
// the saturation digit value.
package seg_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_e;

  localparam logic [3:0] BCD_NINE = 4'd9;

  // Decimal digits needed to hold any unsigned value of 'width' bits.
  // This is ceil(width * log10(2)), using log10(2) ~= 0.30103 scaled by 1e5.
  // The product is never an exact integer for the widths this block supports,
  // so rounding up is always correct.
  function automatic int bcd_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/seg_scan.sv
// Digit scanner for the multiplexed display.
// A refresh divider holds each digit for REFRESH_DIV cycles, then moves the
// scan index on. digit_en and bcd are registered copies of the selected slot.
// The optional macro LEADING_ZERO_BLANK_EN masks the enables of leading zero
// digits. Digit 0 is never masked.
module seg_scan
  import seg_display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS*4-1:0] display,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic [3:0]              bcd
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [DIV_W-1:0]      div_q, div_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
  logic [3:0]            bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0] blank;

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blanked when it and every digit above it are zero.
  // The display only changes at commit, so the mask follows each commit.
  always_comb begin
    logic upper_zero;
    blank      = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (display[i*4 +: 4] == 4'd0);
      blank[i]   = upper_zero;
    end
  end
`else
  // Without blanking, every digit takes its turn on the bus.
  always_comb begin
    blank = '0;
  end
`endif

  // Advance the divider every cycle and the scan index on divider wrap.
  // Register the enable and BCD code of the current slot.
  always_comb begin
    div_d      = div_q + DIV_W'(1);
    idx_d      = idx_q;
    if (div_q == DIV_W'(REFRESH_DIV - 1)) begin
      div_d = '0;
      if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
    digit_en_d = (NUM_DIGITS'(1) << idx_q) & ~blank;
    bcd_d      = display[idx_q*4 +: 4];
  end

  // Scan state and output registers; reset leaves the bus dark.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q      <= '0;
      idx_q      <= '0;
      digit_en_q <= '0;
      bcd_q      <= '0;
    end else begin
      div_q      <= div_d;
      idx_q      <= idx_d;
      digit_en_q <= digit_en_d;
      bcd_q      <= bcd_d;
    end
  end

  assign digit_en = digit_en_q;
  assign bcd      = bcd_q;

endmodule

// File: rtl/seg_display_mux.sv
// Multiplexed N-digit decimal display driver.
// Accepts a binary value on valid/ready and converts it to BCD with a
// sequential shift-add-3 engine. The result is committed atomically, with
// saturation to all nines on overflow. The scan is handled by seg_scan.
// The optional macro LEADING_ZERO_BLANK_EN (see seg_scan) blanks leading zeros.
module seg_display_mux
  import seg_display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DATA_W      = 12,
  parameter int REFRESH_DIV = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     value,
  input  logic                  valid,
  output logic                  ready,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic [3:0]            bcd,
  output logic                  overflow
);

  localparam int CONV_DIGITS = bcd_digits(DATA_W);
  localparam int EXT_DIGITS  = (CONV_DIGITS > NUM_DIGITS) ? CONV_DIGITS : NUM_DIGITS;
  localparam int EXT_W       = EXT_DIGITS * 4;
  localparam int CNT_W       = $clog2(DATA_W + 1);

  state_e                  state_q, state_d;
  logic [DATA_W-1:0]       shift_q, shift_d;
  logic [CONV_DIGITS*4-1:0] acc_q, acc_d, acc_adj;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_DIGITS*4-1:0] display_q, display_d;
  logic                    overflow_q, overflow_d;
  logic [EXT_W-1:0]        acc_ext;
  logic                    high_nonzero;

  // Accumulator widened to cover both the conversion and display digit counts.
  assign acc_ext = EXT_W'(acc_q);

  // Add-3 correction applied to each nibble before it is shifted.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < CONV_DIGITS; i++) begin
      if (acc_q[i*4 +: 4] >= 4'd5) begin
        acc_adj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  // Any non-zero digit above the displayable range means overflow.
  always_comb begin
    high_nonzero = 1'b0;
    for (int i = NUM_DIGITS; i < EXT_DIGITS; i++) begin
      if (acc_ext[i*4 +: 4] != 4'd0) begin
        high_nonzero = 1'b1;
      end
    end
  end

  // Conversion FSM: load in IDLE, one shift per cycle, then commit.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    display_d  = display_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (valid) begin
          shift_d = value;
          acc_d   = '0;
          cnt_d   = CNT_W'(DATA_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {acc_d, shift_d} = {acc_adj, shift_q} << 1;
        cnt_d            = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        if (high_nonzero) begin
          overflow_d = 1'b1;
          display_d  = {NUM_DIGITS{BCD_NINE}};
        end else begin
          overflow_d = 1'b0;
          display_d  = acc_ext[NUM_DIGITS*4-1:0];
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Conversion and display registers. Reset abandons any conversion in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      display_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      display_q  <= display_d;
      overflow_q <= overflow_d;
    end
  end

  assign ready    = (state_q == IDLE);
  assign overflow = overflow_q;

  seg_scan #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) u_scan (
    .clk      (clk),
    .reset    (reset),
    .display  (display_q),
    .digit_en (digit_en),
    .bcd      (bcd)
  );

endmodule
